// File: rtl/ysyx_23060111_mem_resp.sv
// ysyx_23060111_mem_resp: valid/ready memory responder with programmable latency over a word SRAM
module ysyx_23060111_mem_resp #(
  parameter logic [31:0] BASE  = 32'h80000000,
  parameter int          DEPTH = 1024,
  parameter int          LAT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LAT + 1);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic wen_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0] wmask_q;
  logic [31:0] mem [DEPTH];
  logic acc_wen, acc, hit, accept, done;
  logic [31:0] acc_addr, acc_wdata, off;
  logic [3:0] acc_wmask;
  logic [AW-1:0] idx;
  assign req_ready  = state == IDLE;
  assign resp_valid = state == RESP;
  assign accept     = req_ready & req_valid;
  assign done       = resp_valid & resp_ready;
  // With LAT==1 the access happens on the accept edge straight from the request pins
  always_comb begin
    acc_wen   = state == IDLE ? req_wen : wen_q;
    acc_addr  = state == IDLE ? req_addr : addr_q;
    acc_wdata = state == IDLE ? req_wdata : wdata_q;
    acc_wmask = state == IDLE ? req_wmask : wmask_q;
    off       = acc_addr - BASE;
    hit       = acc_addr >= BASE && off < 32'(4 * DEPTH);
    idx       = off[AW+1:2];
    acc       = state == IDLE ? accept && LAT == 1 : state == BUSY && cnt == CW'(1);
    state_n   = state == IDLE ? (accept ? (LAT == 1 ? RESP : BUSY) : IDLE) :
                state == BUSY ? (acc ? RESP : BUSY) : (done ? IDLE : RESP);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      wen_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        wen_q   <= req_wen;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wmask_q <= req_wmask;
        cnt     <= CW'(LAT - 1);
      end else if (state == BUSY) cnt <= cnt - CW'(1);
      if (acc) begin
        resp_rdata <= hit && !acc_wen ? mem[idx] : '0;
        resp_err   <= !hit;
      end else if (done) begin
        resp_rdata <= '0;
        resp_err   <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && acc && hit && acc_wen)
      for (int i = 0; i < 4; i++)
        if (acc_wmask[i]) mem[idx][8*i+:8] <= acc_wdata[8*i+:8];
  end
endmodule

// File: tb/tb_ysyx_23060111_mem_resp.sv
// tb_ysyx_23060111_mem_resp: directed and random transactions against a word-array reference model
module tb_ysyx_23060111_mem_resp;
  localparam logic [31:0] BASE = 32'h80000000;
  localparam int DEPTH = 1024;
  localparam int LAT = 3;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_wen = 0, resp_ready = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [3:0] req_wmask = 0;
  logic req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  int checks = 0, errors = 0;
  logic [31:0] mdl [DEPTH];
  logic [31:0] last_rdata;
  logic last_err;
  always #5 clk = ~clk;
  ysyx_23060111_mem_resp #(.BASE(BASE), .DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic bit in_range(input logic [31:0] a);
    longint ua = longint'(a);
    return ua >= longint'(BASE) && ua < longint'(BASE) + 4 * DEPTH;
  endfunction
  task automatic scramble();
    req_wen = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_wmask = 4'($urandom);
  endtask
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m, input int hold);
    int n = 0;
    logic [31:0] exp_rd, rd0;
    logic exp_err, err0;
    int widx = int'((a - BASE) >> 2);
    req_valid = 1; req_wen = w; req_addr = a; req_wdata = d; req_wmask = m;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    check("req_ready_idle", req_ready, 1);
    exp_err = !in_range(a);
    exp_rd = (!w && !exp_err) ? mdl[widx] : 32'h0;
    @(negedge clk);
    req_valid = 0; scramble();
    n = 1;
    while (!resp_valid && n < 20) begin
      check("req_ready_busy", req_ready, 0);
      @(negedge clk); n++;
    end
    check("latency", n, LAT);
    check("req_ready_resp", req_ready, 0);
    check("rdata", resp_rdata, exp_rd);
    check("err", resp_err, exp_err);
    rd0 = resp_rdata; err0 = resp_err;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", resp_valid, 1);
      check("hold_rdata", resp_rdata, rd0);
      check("hold_err", resp_err, err0);
      check("hold_ready", req_ready, 0);
    end
    resp_ready = 1;
    @(negedge clk);
    resp_ready = 0;
    check("resp_drop", resp_valid, 0);
    check("req_ready_back", req_ready, 1);
    last_rdata = rd0; last_err = err0;
    if (w && !exp_err)
      for (int i = 0; i < 4; i++) if (m[i]) mdl[widx][8*i+:8] = d[8*i+:8];
  endtask
  function automatic logic [31:0] rand_addr();
    logic [31:0] oor [5] = '{32'h7FFFFFFC, BASE + 4 * DEPTH, 32'h0, 32'hFFFFFFFC, BASE + 4 * DEPTH + 32'h100};
    logic [31:0] lo = 32'($urandom_range(0, 3));
    int k = $urandom_range(0, 9);
    if (k < 2) return oor[$urandom_range(0, 4)];
    if (k == 2) return BASE + 4 * (DEPTH - 1) + lo;
    return BASE + 4 * $urandom_range(0, 15) + lo;
  endfunction
  initial begin
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_rdata", resp_rdata, 0);
    check("rst_err", resp_err, 0);
    rst = 0;
    for (int i = 0; i < 16; i++) txn(1, BASE + 4 * i, $urandom, 4'hF, 0);
    txn(1, BASE + 4 * (DEPTH - 1), $urandom, 4'hF, 0);
    txn(1, 32'h80000040, 32'h00009117, 4'hF, 0);
    txn(0, 32'h80000040, 0, 0, 0);
    check("t1_rdata", last_rdata, 32'h00009117);
    check("t1_err", last_err, 0);
    txn(1, 32'h80000044, 32'h11223344, 4'hF, 0);
    txn(1, 32'h80000044, 32'hAABBCCDD, 4'b0101, 1);
    txn(0, 32'h80000044, 0, 0, 0);
    check("t2_rdata", last_rdata, 32'h11BB33DD);
    txn(1, 32'h80000044, 32'hFFFFFFFF, 4'h0, 0);
    txn(0, 32'h80000046, 0, 0, 5);
    check("nomask_rdata", last_rdata, 32'h11BB33DD);
    txn(0, 32'h7FFFFFFC, 0, 0, 0);
    check("t5_lo_err", last_err, 1);
    txn(0, BASE + 4 * DEPTH, 0, 0, 0);
    check("t5_hi_err", last_err, 1);
    check("t5_hi_rdata", last_rdata, 0);
    txn(1, BASE + 4 * DEPTH, 32'hDEADBEEF, 4'hF, 0);
    txn(1, 32'h7FFFFFFC, 32'hDEADBEEF, 4'hF, 0);
    txn(0, BASE, 0, 0, 0);
    txn(0, BASE + 4 * (DEPTH - 1), 0, 0, 0);
    req_valid = 1; req_wen = 1; req_addr = 32'h80000040; req_wdata = 32'hCAFEF00D; req_wmask = 4'hF;
    @(negedge clk);
    req_valid = 0;
    check("t6_busy", req_ready, 0);
    rst = 1;
    @(negedge clk);
    check("t6_req_ready", req_ready, 1);
    check("t6_resp_valid", resp_valid, 0);
    check("t6_rdata", resp_rdata, 0);
    check("t6_err", resp_err, 0);
    rst = 0;
    repeat (2) @(negedge clk);
    check("t6_still_idle", resp_valid, 0);
    txn(0, 32'h80000040, 0, 0, 0);
    check("t6_old_data", last_rdata, 32'h00009117);
    for (int t = 0; t < 80; t++) begin
      if ($urandom_range(0, 3) == 0) begin scramble(); repeat ($urandom_range(1, 3)) @(negedge clk); end
      txn(1'($urandom), rand_addr(), $urandom, 4'($urandom), $urandom_range(0, 3));
    end
    for (int i = 0; i < 16; i++) txn(0, BASE + 4 * i, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
